// File: rtl/tmds_encoder.sv
// tmds_encoder: three-stage DVI 1.0 TMDS 8b/10b encoder for one colour channel.
// Stage 1 counts ones, stage 2 builds the transition-minimised q_m, stage 3 balances DC.
module tmds_encoder (
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] data_in,
  input  logic       c0,
  input  logic       c1,
  input  logic       de,
  output logic [9:0] data_out
);
  logic [7:0]        r_d1;
  logic [3:0]        r_n1d;
  logic              r_de1, r_c0_1, r_c1_1;
  logic [8:0]        r_qm;
  logic [3:0]        r_n1q, r_n0q;
  logic              r_de2, r_c0_2, r_c1_2;
  logic signed [4:0] r_cnt;
  logic              w_dec1, w_dec2, w_dec3;
  logic [8:0]        w_qm;
  logic [3:0]        w_n1q;
  logic signed [4:0] w_bal, w_q8x2, w_nq8x2, w_cnt;
  logic [9:0]        w_tok, w_out;

  function automatic logic [3:0] f_ones(input logic [7:0] v);
    f_ones = '0;
    for (int i = 0; i < 8; i++) f_ones = f_ones + {3'b000, v[i]};
  endfunction

  // XNOR chain is the XOR chain with every stage inverted
  function automatic logic [8:0] f_qm(input logic [7:0] d, input logic inv);
    f_qm[0] = d[0];
    for (int i = 1; i < 8; i++) f_qm[i] = f_qm[i-1] ^ d[i] ^ inv;
    f_qm[8] = ~inv;
  endfunction

  assign w_dec1  = (r_n1d > 4'd4) || (r_n1d == 4'd4 && !r_d1[0]);
  assign w_qm    = f_qm(r_d1, w_dec1);
  assign w_n1q   = f_ones(w_qm[7:0]);
  assign w_bal   = $signed({1'b0, r_n1q}) - $signed({1'b0, r_n0q});
  assign w_q8x2  = $signed({3'b000, r_qm[8], 1'b0});
  assign w_nq8x2 = $signed({3'b000, ~r_qm[8], 1'b0});
  assign w_dec2  = (r_cnt == 5'sd0) || (r_n1q == r_n0q);
  assign w_dec3  = (r_cnt > 5'sd0 && r_n1q > r_n0q) || (r_cnt < 5'sd0 && r_n0q > r_n1q);

  assign w_tok = {r_c1_2, r_c0_2} == 2'b00 ? 10'b1101010100 :
                 {r_c1_2, r_c0_2} == 2'b01 ? 10'b0010101011 :
                 {r_c1_2, r_c0_2} == 2'b10 ? 10'b0101010100 : 10'b1010101011;

  assign w_out = !r_de2 ? w_tok :
                 w_dec2 ? {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]} :
                 w_dec3 ? {1'b1, r_qm[8], ~r_qm[7:0]} : {1'b0, r_qm[8], r_qm[7:0]};

  // cnt tracks the ones-minus-zeros of every emitted 10-bit character
  assign w_cnt = !r_de2 ? 5'sd0 :
                 w_dec2 ? (r_qm[8] ? r_cnt + w_bal : r_cnt - w_bal) :
                 w_dec3 ? r_cnt + w_q8x2 - w_bal : r_cnt - w_nq8x2 + w_bal;

  always_ff @(posedge vga_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      r_d1     <= '0;
      r_n1d    <= '0;
      r_de1    <= 1'b0;
      r_c0_1   <= 1'b0;
      r_c1_1   <= 1'b0;
      r_qm     <= '0;
      r_n1q    <= '0;
      r_n0q    <= '0;
      r_de2    <= 1'b0;
      r_c0_2   <= 1'b0;
      r_c1_2   <= 1'b0;
      r_cnt    <= '0;
      data_out <= '0;
    end else begin
      r_d1     <= data_in;
      r_n1d    <= f_ones(data_in);
      r_de1    <= de;
      r_c0_1   <= c0;
      r_c1_1   <= c1;
      r_qm     <= w_qm;
      r_n1q    <= w_n1q;
      r_n0q    <= 4'd8 - w_n1q;
      r_de2    <= r_de1;
      r_c0_2   <= r_c0_1;
      r_c1_2   <= r_c1_1;
      r_cnt    <= w_cnt;
      data_out <= w_out;
    end
endmodule

// File: tb/tb_tmds_encoder.sv
// tb_tmds_encoder: directed and random checks of tmds_encoder against a behavioural model.
module tb_tmds_encoder;
  logic       vga_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [7:0] data_in = '0;
  logic       c0 = 1'b0, c1 = 1'b0, de = 1'b0;
  logic [9:0] data_out;
  int         n_cmp = 0, n_bad = 0;
  int         m_cnt = 0, disp = 0;
  logic [10:0] pipe[$];
  logic [9:0] tok[4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  tmds_encoder dut (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .data_in(data_in),
    .c0(c0), .c1(c1), .de(de), .data_out(data_out)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic int ones(input logic [9:0] v);
    int n = 0;
    for (int i = 0; i < 10; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Character = {de, c1, c0, data}; cnt is kept as the running 10-bit disparity
  task automatic model_enc(input logic [10:0] x, output logic [9:0] o);
    logic [7:0] d, qm;
    logic inv, p;
    int n1, b;
    d = x[7:0];
    if (!x[10]) begin
      o = tok[x[9:8]];
      m_cnt = 0;
    end else begin
      n1 = ones({2'b00, d});
      inv = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
      p = 1'b0;
      for (int i = 0; i < 8; i++) begin
        p = p ^ d[i];
        qm[i] = p ^ (inv && (i % 2 == 1));
      end
      b = 2 * ones({2'b00, qm}) - 8;
      if (m_cnt == 0 || b == 0) o = inv ? {2'b10, ~qm} : {2'b01, qm};
      else if ((m_cnt > 0 && b > 0) || (m_cnt < 0 && b < 0)) o = {1'b1, !inv, ~qm};
      else o = {1'b0, !inv, qm};
      m_cnt += 2 * ones(o) - 10;
    end
  endtask

  task automatic model_reset();
    pipe = {11'd0, 11'd0};
    m_cnt = 0;
    disp = 0;
  endtask

  task automatic step(input logic [7:0] d, input logic e, input logic a0, input logic a1);
    logic [10:0] x;
    logic [9:0] exp;
    data_in = d; de = e; c0 = a0; c1 = a1;
    pipe.push_back({e, a1, a0, d});
    @(posedge vga_clk); #1;
    x = pipe.pop_front();
    model_enc(x, exp);
    chk("model", data_out, exp);
    if (x[10]) begin
      disp += 2 * ones(data_out) - 10;
      n_cmp++;
      assert (disp <= 10 && disp >= -10) else begin
        n_bad++;
        $error("FAIL dc_balance: observed %0d expected within +/-10", disp);
      end
    end else disp = 0;
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) step(8'($urandom), 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      data_in = 8'($urandom); de = 1'($urandom); c0 = 1'($urandom); c1 = 1'($urandom);
      @(posedge vga_clk); #1;
      chk("reset_hold", data_out, 10'h000);
    end
    sys_rst_n = 1'b1;
    model_reset();
    step(8'($urandom), 1'b1, 1'b0, 1'b0);
    chk("release_1", data_out, 10'h354);
    step(8'($urandom), 1'b1, 1'b0, 1'b0);
    chk("release_2", data_out, 10'h354);
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 3; k++) step(8'($urandom), 1'b0, c[0], c[1]);
      chk("token", data_out, tok[c]);
    end
    blank(3);
    for (int k = 0; k < 3; k++) step(8'h00, 1'b1, 1'b0, 1'b0);
    chk("zero_1", data_out, 10'h100);
    chk("zero_cnt1", {5'b0, dut.r_cnt}, 10'b00000_11000);
    step(8'h00, 1'b0, 1'b0, 1'b0);
    chk("zero_2", data_out, 10'h3FF);
    chk("zero_cnt2", {5'b0, dut.r_cnt}, 10'b00000_00010);
    step(8'h00, 1'b0, 1'b0, 1'b0);
    chk("zero_3", data_out, 10'h100);
    chk("zero_cnt3", {5'b0, dut.r_cnt}, 10'b00000_11010);
    blank(3);
    step(8'hFF, 1'b1, 1'b0, 1'b0);
    blank(2);
    chk("ones", data_out, 10'h200);
    chk("ones_cnt", {5'b0, dut.r_cnt}, 10'b00000_11000);
    blank(3);
    step(8'h00, 1'b1, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b0);
    step(8'h00, 1'b1, 1'b0, 1'b0);
    blank(2);
    chk("blank_clear", data_out, 10'h100);
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 640; i++) step(8'($urandom), 1'b1, 1'($urandom), 1'($urandom));
      blank(4);
    end
    for (int i = 0; i < 200; i++)
      step(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    for (int i = 0; i < 50; i++) step(8'($urandom), 1'b1, 1'b0, 1'b0);
    #2 sys_rst_n = 1'b0;
    #1 chk("midframe_rst", data_out, 10'h000);
    @(posedge vga_clk); #1;
    chk("midframe_hold", data_out, 10'h000);
    sys_rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 200; i++) step(8'($urandom), 1'b1, 1'b0, 1'b0);
    blank(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
